usb_pulpino_tx_fifo: RTL and testbench

//  Byte FIFO plus toggle ("flicker") handshake between the USB register side and the PULPino GPIO.
//  - Sits directly upstream of PULPino gpio_in: buffers bytes strobed from the USB register block.
//  - Presents buffered bytes one at a time: data byte plus a toggling data flicker.
//  - Pops the next byte only after PULPino firmware toggles the ack flicker on gpio_out.
//  - Host may burst up to pDEPTH bytes without per-byte polling.

---
 rtl/usb_pulpino_tx_fifo.sv | 73 +++++++
 tb/tb_usb_pulpino_tx_fifo.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_pulpino_tx_fifo.sv
// usb_pulpino_tx_fifo: byte FIFO feeding PULPino gpio_in with a toggle (flicker) handshake
// A byte is popped only while idle; the next pop waits for PULPino to toggle the ack flicker.
module usb_pulpino_tx_fifo #(
    parameter int pDATA_WIDTH = 8,
    parameter int pDEPTH_LOG2 = 4
) (
    input  logic                   clk,
    input  logic                   reset_i,
    input  logic                   clear_i,
    input  logic                   wr_valid_i,
    input  logic [pDATA_WIDTH-1:0] wr_data_i,
    output logic                   full_o,
    output logic [pDEPTH_LOG2:0]   level_o,
    output logic                   overflow_o,
    output logic [pDATA_WIDTH-1:0] pulpino_data_o,
    output logic                   data_flicker_o,
    input  logic                   ack_flicker_i,
    output logic                   busy_o
);
    localparam logic [pDEPTH_LOG2:0] FULL_LVL = (pDEPTH_LOG2+1)'(1) << pDEPTH_LOG2;
    typedef enum logic {IDLE, WAIT_ACK} state_t;
    logic [pDATA_WIDTH-1:0] mem_q [1<<pDEPTH_LOG2];
    logic [pDEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [pDEPTH_LOG2:0]   level_q, level_d;
    logic [pDATA_WIDTH-1:0] data_q;
    logic                   flicker_q, overflow_q, ack_prev_q;
    state_t                 state_q;
    logic                   wr_en, pop;
    assign full_o         = level_q == FULL_LVL;
    assign level_o        = level_q;
    assign overflow_o     = overflow_q;
    assign pulpino_data_o = data_q;
    assign data_flicker_o = flicker_q;
    assign busy_o         = state_q == WAIT_ACK;
    // full is judged on the registered level, so a same-cycle pop never frees room for a write
    assign wr_en   = wr_valid_i && !full_o && !clear_i;
    assign pop     = state_q == IDLE && level_q != '0 && !clear_i;
    assign level_d = (wr_en && !pop) ? level_q + 1'b1 : (pop && !wr_en) ? level_q - 1'b1 : level_q;
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data_i;
    end
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            data_q     <= '0;
            flicker_q  <= 1'b0;
            overflow_q <= 1'b0;
            ack_prev_q <= 1'b0;
            state_q    <= IDLE;
        end else if (clear_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            ack_prev_q <= ack_flicker_i;
            state_q    <= IDLE;
        end else begin
            if (wr_valid_i && full_o) overflow_q <= 1'b1;
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                data_q    <= mem_q[rd_ptr_q];
                flicker_q <= ~flicker_q;
            end
            level_q <= level_d;
            // tracking ack every cycle makes toggles outside WAIT_ACK harmless
            ack_prev_q <= ack_flicker_i;
            state_q    <= pop ? WAIT_ACK : (state_q == WAIT_ACK && ack_flicker_i != ack_prev_q) ? IDLE : state_q;
        end
    end
endmodule

// File: tb/tb_usb_pulpino_tx_fifo.sv
// tb_usb_pulpino_tx_fifo: directed scenarios plus random traffic against a queue-based model
module tb_usb_pulpino_tx_fifo;
    logic       clk = 1'b0;
    logic       reset_i = 1'b1, clear_i = 1'b0, wr_valid_i = 1'b0, ack_flicker_i = 1'b0;
    logic [7:0] wr_data_i = '0;
    logic       full_o, overflow_o, data_flicker_o, busy_o;
    logic [4:0] level_o;
    logic [7:0] pulpino_data_o;
    int checks = 0, failures = 0;
    logic [7:0] mq[$];
    logic [7:0] m_data;
    logic       m_flick, m_busy, m_ovf, m_ackp;

    usb_pulpino_tx_fifo dut (
        .clk(clk), .reset_i(reset_i), .clear_i(clear_i), .wr_valid_i(wr_valid_i),
        .wr_data_i(wr_data_i), .full_o(full_o), .level_o(level_o), .overflow_o(overflow_o),
        .pulpino_data_o(pulpino_data_o), .data_flicker_o(data_flicker_o),
        .ack_flicker_i(ack_flicker_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        m_data = '0; m_flick = 0; m_busy = 0; m_ovf = 0; m_ackp = 0;
    endtask

    // one clock of the behaviour: bytes live in a queue, the presented byte is waiting for an ack
    task automatic model_step();
        logic full, take;
        if (clear_i) begin
            mq.delete(); m_ovf = 0; m_busy = 0; m_ackp = ack_flicker_i;
            return;
        end
        full = mq.size() == 16;
        take = !m_busy && mq.size() != 0;
        if (wr_valid_i && full) m_ovf = 1;
        if (m_busy && ack_flicker_i != m_ackp) m_busy = 0;
        if (take) begin m_data = mq.pop_front(); m_flick = ~m_flick; m_busy = 1; end
        if (wr_valid_i && !full) mq.push_back(wr_data_i);
        m_ackp = ack_flicker_i;
    endtask

    function automatic logic [16:0] expv();
        return {mq.size() == 16, 5'(mq.size()), m_ovf, m_data, m_flick, m_busy};
    endfunction

    function automatic logic [16:0] actv();
        return {full_o, level_o, overflow_o, pulpino_data_o, data_flicker_o, busy_o};
    endfunction

    task automatic cycle(input logic wr, input logic [7:0] d, input logic clr);
        wr_valid_i = wr; wr_data_i = d; clear_i = clr;
        @(posedge clk);
        model_step();
        @(negedge clk);
        wr_valid_i = 0; clear_i = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_i = 1; wr_valid_i = 0; clear_i = 0; ack_flicker_i = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_i = 0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        reset_i = 1;
        #1;
        checks++;
        if (actv() !== 17'h0) begin failures++; $display("FAIL reset_outputs got=%h want=%h", actv(), 17'h0); end
        @(negedge clk);
        reset_i = 0;
        model_reset();
    endtask

    task automatic test_latency();
        cycle(1, 8'hA5, 0);
        checks++;
        if (data_flicker_o !== 1'b0) begin failures++; $display("FAIL latency_c1_flicker got=%b want=0", data_flicker_o); end
        cycle(0, 8'h00, 0);
        checks++;
        if ({pulpino_data_o, data_flicker_o, busy_o, level_o} !== {8'hA5, 1'b1, 1'b1, 5'd0}) begin
            failures++;
            $display("FAIL latency_c2 got=%h/%b/%b/%0d want=a5/1/1/0", pulpino_data_o, data_flicker_o, busy_o, level_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seen[$];
        logic last;
        int toggles = 0;
        do_reset();
        last = data_flicker_o;
        for (int k = 0; k < 40; k++) begin
            cycle(k < 5, 8'(k + 1), 0);
            if (data_flicker_o !== last) begin
                seen.push_back(pulpino_data_o);
                toggles++;
                last = data_flicker_o;
                ack_flicker_i = ~ack_flicker_i;
            end
        end
        checks++;
        if (toggles != 5) begin failures++; $display("FAIL b2b_toggles got=%0d want=5", toggles); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (seen.size() <= i || seen[i] !== 8'(i + 1)) begin
                failures++;
                $display("FAIL b2b_order idx=%0d got=%h want=%h", i, (seen.size() > i) ? seen[i] : 8'hxx, 8'(i + 1));
            end
        end
        checks++;
        if ({level_o, busy_o} !== {5'd0, 1'b0}) begin failures++; $display("FAIL b2b_end got=%0d/%b want=0/0", level_o, busy_o); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 17; i++) cycle(1, 8'(8'h10 + i), 0);
        checks++;
        if ({full_o, level_o, overflow_o, pulpino_data_o} !== {1'b1, 5'd16, 1'b0, 8'h10}) begin
            failures++;
            $display("FAIL fill17 got=%b/%0d/%b/%h want=1/16/0/10", full_o, level_o, overflow_o, pulpino_data_o);
        end
        cycle(1, 8'h99, 0);
        checks++;
        if ({overflow_o, full_o, level_o} !== {1'b1, 1'b1, 5'd16}) begin
            failures++;
            $display("FAIL write18 got=%b/%b/%0d want=1/1/16", overflow_o, full_o, level_o);
        end
        ack_flicker_i = 1;
        cycle(1, 8'hEE, 0);
        checks++;
        if ({overflow_o, level_o, busy_o} !== {1'b1, 5'd16, 1'b0}) begin
            failures++;
            $display("FAIL ack_full_wr got=%b/%0d/%b want=1/16/0", overflow_o, level_o, busy_o);
        end
        cycle(0, 8'h00, 0);
        checks++;
        if ({level_o, busy_o, pulpino_data_o, data_flicker_o} !== {5'd15, 1'b1, 8'h11, 1'b0}) begin
            failures++;
            $display("FAIL ack_full_pop got=%0d/%b/%h/%b want=15/1/11/0", level_o, busy_o, pulpino_data_o, data_flicker_o);
        end
        checks++;
        if (actv() !== expv()) begin failures++; $display("FAIL overflow_model got=%h want=%h", actv(), expv()); end
    endtask

    task automatic test_clear();
        logic f;
        for (int r = 0; r < 40 && level_o > 5'd3; r++) begin
            ack_flicker_i = ~ack_flicker_i;
            cycle(0, 8'h00, 0);
            cycle(0, 8'h00, 0);
        end
        checks++;
        if ({level_o, busy_o, overflow_o} !== {5'd3, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL clear_pre got=%0d/%b/%b want=3/1/1", level_o, busy_o, overflow_o);
        end
        f = data_flicker_o;
        cycle(0, 8'h00, 1);
        checks++;
        if ({level_o, busy_o, overflow_o, data_flicker_o} !== {5'd0, 1'b0, 1'b0, f}) begin
            failures++;
            $display("FAIL clear_post got=%0d/%b/%b/%b want=0/0/0/%b", level_o, busy_o, overflow_o, data_flicker_o, f);
        end
        ack_flicker_i = ~ack_flicker_i;
        repeat (3) cycle(0, 8'h00, 0);
        checks++;
        if ({data_flicker_o, busy_o} !== {f, 1'b0}) begin
            failures++;
            $display("FAIL clear_ack_ignored got=%b/%b want=%b/0", data_flicker_o, busy_o, f);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, 8'(8'h40 + i), 0);
        #2 reset_i = 1;
        #1;
        checks++;
        if (actv() !== 17'h0) begin failures++; $display("FAIL async_reset got=%h want=%h", actv(), 17'h0); end
        @(posedge clk);
        @(negedge clk);
        reset_i = 0;
        ack_flicker_i = 0;
        model_reset();
        cycle(1, 8'h5A, 0);
        cycle(0, 8'h00, 0);
        checks++;
        if ({pulpino_data_o, data_flicker_o, busy_o, level_o} !== {8'h5A, 1'b1, 1'b1, 5'd0}) begin
            failures++;
            $display("FAIL after_async got=%h/%b/%b/%0d want=5a/1/1/0", pulpino_data_o, data_flicker_o, busy_o, level_o);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 99) < 35) ack_flicker_i = ~ack_flicker_i;
            cycle($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 2);
            checks++;
            if (actv() !== expv()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h want=%h", k, actv(), expv());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_latency();
        test_back_to_back();
        test_overflow();
        test_clear();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
